mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported synchronous memory.
// Each access runs IDLE -> ACCESS -> RESP; data has priority unless fetch has waited MAX_WAIT grants.
module mem_arbiter #(
   parameter int MAX_WAIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [31:0] read_address,
   output logic [31:0] write_data,
   output logic        write_mem,
   input  logic [31:0] read_data,
   output logic        busy
);
   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          owner_q, owner_d;        // 1 = data port owns the access
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic          d_rvalid_q, d_rvalid_d;
   logic          fetch_wins;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      fetch_wins  = if_req && (!d_req || wait_cnt_q == MAX_CNT);
      unique case (state_q)
         IDLE: begin
            // Grants are gated by reset so every output is low while it is held.
            if (reset && (if_req || d_req)) begin
               state_d = ACCESS;
               if (fetch_wins) begin
                  if_gnt     = 1'b1;
                  owner_d    = 1'b0;
                  addr_d     = if_addr;
                  we_d       = 1'b0;
                  wdata_d    = '0;
                  wait_cnt_d = '0;
               end else begin
                  d_gnt   = 1'b1;
                  owner_d = 1'b1;
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
                  if (!if_req)                   wait_cnt_d = '0;
                  else if (wait_cnt_q != MAX_CNT) wait_cnt_d = wait_cnt_q + CW'(1);
               end
            end
         end
         ACCESS: begin
            state_d     = RESP;
            if_rvalid_d = ~owner_q;
            d_rvalid_d  = owner_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
      end
   end

   // Memory side is only driven during ACCESS; read_data lands in RESP.
   assign busy         = (state_q != IDLE);
   assign read_address = (state_q == ACCESS) ? addr_q  : '0;
   assign write_data   = (state_q == ACCESS) ? wdata_q : '0;
   assign write_mem    = (state_q == ACCESS) && we_q;
   assign if_rvalid    = if_rvalid_q;
   assign d_rvalid     = d_rvalid_q;
   assign if_rdata     = if_rvalid_q ? read_data : '0;
   assign d_rdata      = (d_rvalid_q && !we_q) ? read_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, data write, contention,
// back-to-back, mid-access reset and idle hold.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [31:0] read_address, write_data, read_data;
   logic        write_mem, busy;
   int          checks = 0;
   int          errors = 0;

   mem_arbiter #(.MAX_WAIT(3)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .read_address(read_address), .write_data(write_data), .write_mem(write_mem),
      .read_data(read_data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h10) ? 32'h00A0_0093 : ((a ^ 32'hA5A5_0000) + 32'h1);
   endfunction

   // Synchronous memory: data for the address presented appears the next cycle.
   always @(posedge clk) read_data <= mem_fn(read_address);

   function automatic logic [134:0] all_outs();
      return {if_gnt, d_gnt, busy, if_rvalid, d_rvalid, write_mem, read_address, write_data, if_rdata, d_rdata};
   endfunction

   task automatic test_reset();
      reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
      if_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'hFFFF_FFFF;
      #3;
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", all_outs()); end
      checks++;
      if (dut.wait_cnt_q !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.wait_cnt_q); end
      @(posedge clk); #1;
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL reset_held got %h exp 0", all_outs()); end
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; reset = 1'b1;
   endtask

   task automatic test_single_fetch();
      if_req = 1'b1; if_addr = 32'h10; #1;
      checks++;
      if ({if_gnt, d_gnt, busy} !== 3'b100) begin errors++; $display("FAIL fetch_gnt got %b exp 100", {if_gnt, d_gnt, busy}); end
      @(posedge clk); #1; if_req = 1'b0;
      checks++;
      if ({read_address, write_mem, busy, if_rvalid} !== {32'h10, 3'b010}) begin
         errors++; $display("FAIL fetch_access got %h/%b%b%b exp 10/010", read_address, write_mem, busy, if_rvalid); end
      @(posedge clk); #1;
      checks++;
      if ({if_rvalid, if_rdata, d_rvalid, d_rdata, read_address} !== {1'b1, 32'h00A0_0093, 1'b0, 64'h0}) begin
         errors++; $display("FAIL fetch_resp got rv=%b rd=%h drv=%b drd=%h ra=%h exp 1 00a00093 0 0 0",
                            if_rvalid, if_rdata, d_rvalid, d_rdata, read_address); end
      @(posedge clk); #1;
      checks++;
      if ({busy, if_rvalid, if_rdata} !== 34'h0) begin errors++; $display("FAIL fetch_done got %b %b %h exp 0", busy, if_rvalid, if_rdata); end
   endtask

   task automatic test_data_write();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'hDEAD_BEEF; #1;
      checks++;
      if ({if_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL write_gnt got %b exp 01", {if_gnt, d_gnt}); end
      @(posedge clk); #1; d_req = 1'b0;
      checks++;
      if ({write_mem, read_address, write_data} !== {1'b1, 32'h64, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL write_access got we=%b a=%h d=%h exp 1 64 deadbeef", write_mem, read_address, write_data); end
      @(posedge clk); #1;
      checks++;
      if ({write_mem, d_rvalid, d_rdata, if_rvalid, write_data} !== {2'b01, 32'h0, 1'b0, 32'h0}) begin
         errors++; $display("FAIL write_resp got we=%b rv=%b rd=%h irv=%b wd=%h exp 0 1 0 0 0",
                            write_mem, d_rvalid, d_rdata, if_rvalid, write_data); end
      @(posedge clk); #1; d_we = 1'b0;
      checks++;
      if ({d_rvalid, busy} !== 2'b00) begin errors++; $display("FAIL write_done got %b exp 00", {d_rvalid, busy}); end
   endtask

   task automatic test_contention();
      bit          exp_d[8]   = '{1, 1, 1, 0, 1, 1, 1, 0};
      logic [1:0]  exp_cnt[8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [31:0] ea;
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      for (int i = 0; i < 8; i++) begin
         ea = exp_d[i] ? 32'h200 : 32'h100;
         #1;
         checks++;
         if ({if_gnt, d_gnt} !== {~exp_d[i], exp_d[i]}) begin
            errors++; $display("FAIL cont_gnt[%0d] got if=%b d=%b exp d=%b", i, if_gnt, d_gnt, exp_d[i]); end
         @(posedge clk); #1;
         checks++;
         if ({dut.wait_cnt_q, read_address} !== {exp_cnt[i], ea}) begin
            errors++; $display("FAIL cont_cnt[%0d] got cnt=%0d a=%h exp cnt=%0d a=%h", i, dut.wait_cnt_q, read_address, exp_cnt[i], ea); end
         @(posedge clk); #1;
         checks++;
         if ({d_rvalid, if_rvalid, d_rdata | if_rdata} !== {exp_d[i], ~exp_d[i], mem_fn(ea)}) begin
            errors++; $display("FAIL cont_resp[%0d] got drv=%b irv=%b drd=%h ird=%h exp d=%b data=%h",
                               i, d_rvalid, if_rvalid, d_rdata, if_rdata, exp_d[i], mem_fn(ea)); end
         @(posedge clk);
      end
      #1; if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp_dg   = 6'b001001;
      logic [5:0] exp_busy = 6'b110110;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if ({d_gnt, if_gnt, busy} !== {exp_dg[i], 1'b0, exp_busy[i]}) begin
            errors++; $display("FAIL b2b[%0d] got dg=%b ig=%b busy=%b exp %b 0 %b", i, d_gnt, if_gnt, busy, exp_dg[i], exp_busy[i]); end
         @(posedge clk); #1;
      end
      d_req = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678; #1;
      checks++;
      if ({if_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL rst_gnt got %b exp 01", {if_gnt, d_gnt}); end
      @(posedge clk); #1; if_req = 1'b0; d_req = 1'b0;
      checks++;
      if ({write_mem, dut.wait_cnt_q} !== 3'b101) begin errors++; $display("FAIL rst_pre got we=%b cnt=%0d exp 1 1", write_mem, dut.wait_cnt_q); end
      reset = 1'b0; #1;
      checks++;
      if ({all_outs(), dut.wait_cnt_q} !== '0) begin errors++; $display("FAIL rst_drop got %h cnt=%0d exp 0", all_outs(), dut.wait_cnt_q); end
      @(posedge clk); #1;
      checks++;
      if ({d_rvalid, write_mem, busy} !== 3'b000) begin errors++; $display("FAIL rst_norv got %b exp 000", {d_rvalid, write_mem, busy}); end
      reset = 1'b1; if_req = 1'b1; d_we = 1'b0; #1;
      checks++;
      if ({if_gnt, d_gnt, dut.wait_cnt_q} !== 4'b1000) begin
         errors++; $display("FAIL rst_regrant got ig=%b dg=%b cnt=%0d exp 1 0 0", if_gnt, d_gnt, dut.wait_cnt_q); end
      @(posedge clk); #1; if_req = 1'b0;
      checks++;
      if ({read_address, write_mem} !== {32'h44, 1'b0}) begin errors++; $display("FAIL rst_access got %h %b exp 44 0", read_address, write_mem); end
      @(posedge clk); #1;
      checks++;
      if ({if_rvalid, if_rdata} !== {1'b1, mem_fn(32'h44)}) begin
         errors++; $display("FAIL rst_resp got %b %h exp 1 %h", if_rvalid, if_rdata, mem_fn(32'h44)); end
      @(posedge clk); #1;
   endtask

   task automatic test_idle_hold();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (all_outs() !== '0) begin errors++; $display("FAIL idle[%0d] got %h exp 0", i, all_outs()); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_single_fetch();
      test_data_write();
      test_contention();
      test_back_to_back();
      test_reset_mid_access();
      test_idle_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
